// File: rtl/frequency_generator.sv
// Programmable square-wave source: N = 10*tens + units rising edges per UPDATE_PERIOD clocks,
// produced by a phase accumulator that adds 2N per clock and wraps at UPDATE_PERIOD.
module frequency_generator #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int BITS          = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic       busy,
  output logic       running,
  output logic       signal
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [BITS:0]   PERIOD_W = (BITS+1)'(UPDATE_PERIOD);
  localparam logic [BITS-1:0] PERIOD_B = BITS'(UPDATE_PERIOD);

  state_t          state, state_n;
  logic [BITS-1:0] acc, acc_n;
  logic [7:0]      step, step_n;
  logic [3:0]      tens_left, tens_left_n;
  logic [3:0]      units, units_n;
  logic            busy_n, running_n, signal_n;
  logic            accept;
  logic [BITS-1:0] step_ext;
  logic [BITS:0]   sum;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign accept   = load && (state == IDLE || state == RUN);
  assign step_ext = {{(BITS-8){1'b0}}, step};
  // One extra bit so the wrap test never overflows; the wrapped value itself fits in BITS.
  assign sum      = {1'b0, acc} + {1'b0, step_ext};

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    step_n      = step;
    tens_left_n = tens_left;
    units_n     = units;
    busy_n      = busy;
    running_n   = running;
    signal_n    = signal;

    if (accept) begin
      tens_left_n = clamp_bcd(ten_count);
      units_n     = clamp_bcd(unit_count);
      step_n      = 8'd0;
      acc_n       = '0;
      busy_n      = 1'b1;
      running_n   = 1'b0;
      state_n     = CONVERT;
    end else begin
      case (state)
        IDLE: signal_n = 1'b0;
        CONVERT: begin
          if (tens_left != 4'd0) begin
            step_n      = step + 8'd20;
            tens_left_n = tens_left - 4'd1;
          end else begin
            step_n    = step + {3'b000, units, 1'b0};
            busy_n    = 1'b0;
            running_n = (step_n != 8'd0);
            state_n   = RUN;
          end
        end
        RUN: begin
          if (step == 8'd0) begin
            signal_n = 1'b0;
          end else if (sum >= PERIOD_W) begin
            acc_n    = acc + step_ext - PERIOD_B;
            signal_n = ~signal;
          end else begin
            acc_n = sum[BITS-1:0];
          end
        end
        default: begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          running_n = 1'b0;
          signal_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      step      <= 8'd0;
      tens_left <= 4'd0;
      units     <= 4'd0;
      busy      <= 1'b0;
      running   <= 1'b0;
      signal    <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      step      <= step_n;
      tens_left <= tens_left_n;
      units     <= units_n;
      busy      <= busy_n;
      running   <= running_n;
      signal    <= signal_n;
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: closed-form rate model checked every cycle, plus directed edge counts.
`timescale 1ns/1ps
module tb_frequency_generator;
  localparam int P = 1200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] ten_count = 4'd0;
  logic [3:0] unit_count = 4'd0;
  logic       busy, running, signal;

  int checks = 0;
  int fails  = 0;

  frequency_generator #(.UPDATE_PERIOD(P), .BITS(12)) dut (
    .clk(clk), .reset(reset), .load(load), .ten_count(ten_count),
    .unit_count(unit_count), .busy(busy), .running(running), .signal(signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampd(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  // Model: after RUN entry, toggles after k cycles = floor(k*2N/P); busy lasts tens+1 cycles.
  int     m_mode = 0;        // 0 idle, 1 converting, 2 running
  int     m_busy_left = 0;
  int     m_n = 0;
  longint m_k = 0;
  bit     m_lvl0 = 1'b0;
  bit     m_sig = 1'b0;
  bit     m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode  = 0;
      m_sig   = 1'b0;
      m_valid = 1'b1;
    end else if (load && m_mode != 1) begin
      m_n         = 10 * clampd(int'(ten_count)) + clampd(int'(unit_count));
      m_busy_left = clampd(int'(ten_count)) + 1;
      m_mode      = 1;
    end else if (m_mode == 1) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_mode = 2;
        m_k    = 0;
        m_lvl0 = m_sig;
      end
    end else if (m_mode == 2) begin
      m_k++;
      if (m_n == 0) m_sig = 1'b0;
      else          m_sig = m_lvl0 ^ ((((m_k * 2 * m_n) / P) % 2) != 0);
    end else begin
      m_sig = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", busy, (m_mode == 1));
      check("model_running", running, (m_mode == 2 && m_n != 0));
      check("model_signal", signal, m_sig);
    end
  end

  task automatic do_load(input int t, input int u);
    @(negedge clk);
    load = 1'b1; ten_count = 4'(t); unit_count = 4'(u);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic observe(input int cycles, output int rises, output int toggles,
                         output int minp, output int maxp);
    logic prev;
    int   run;
    bit   first;
    prev = signal; run = 0; first = 1'b1;
    rises = 0; toggles = 0; minp = 1 << 30; maxp = 0;
    repeat (cycles) begin
      @(negedge clk);
      run++;
      if (signal != prev) begin
        toggles++;
        if (signal) rises++;
        if (!first) begin
          if (run < minp) minp = run;
          if (run > maxp) maxp = run;
        end
        first = 1'b0;
        run = 0;
      end
      prev = signal;
    end
  endtask

  task automatic wait_high();
    int c;
    c = 0;
    while (signal == 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("wait_signal_high", signal, 1);
  endtask

  int bc, c, r, tg, mn, mx;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_running", running, 0);
    check("reset_signal", signal, 0);
    reset = 1'b0;

    // 0/5: step 10, toggle every 120 cycles
    do_load(0, 5);
    wait_busy(bc);
    check("busy_len_05", bc, 1);
    check("running_05", running, 1);
    c = 0;
    while (signal == 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("first_toggle_05", c, 120);
    observe(P, r, tg, mn, mx);
    check("rises_05", r, 5);
    check("spacing_min_05", mn, 120);
    check("spacing_max_05", mx, 120);

    // 9/9 reloaded from RUN
    do_load(9, 9);
    wait_busy(bc);
    check("busy_len_99", bc, 10);
    observe(P, r, tg, mn, mx);
    check("rises_99", r, 99);
    check("phase_min_99", mn, 6);
    check("phase_max_99", mx, 7);

    // 0/0 loaded while the output is high
    wait_high();
    do_load(0, 0);
    wait_busy(bc);
    check("busy_len_00", bc, 1);
    check("running_00", running, 0);
    @(negedge clk);
    check("signal_00", signal, 0);
    observe(2000, r, tg, mn, mx);
    check("toggles_00", tg, 0);
    check("signal_00_end", signal, 0);

    // 4/2 with a second load during busy cycle 2 that must be ignored
    do_load(4, 2);
    @(negedge clk);
    load = 1'b1; ten_count = 4'd0; unit_count = 4'd1;
    @(negedge clk);
    load = 1'b0;
    wait_busy(bc);
    check("busy_rest_42", bc, 3);
    observe(P, r, tg, mn, mx);
    check("rises_42", r, 42);

    // out-of-range digits clamp to 9/9
    do_load(15, 12);
    wait_busy(bc);
    check("busy_len_clamp", bc, 10);
    observe(P, r, tg, mn, mx);
    check("rises_clamp", r, 99);

    // reset in RUN while high
    wait_high();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_run_signal", signal, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_running", running, 0);
    reset = 1'b0;
    observe(300, r, tg, mn, mx);
    check("rst_run_toggles", tg, 0);

    // reset in CONVERT
    do_load(9, 9);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_conv_busy", busy, 0);
    check("rst_conv_running", running, 0);
    check("rst_conv_signal", signal, 0);
    reset = 1'b0;
    observe(300, r, tg, mn, mx);
    check("rst_conv_toggles", tg, 0);
    check("rst_conv_busy_after", busy, 0);

    // 2/7 as a counter would see it over consecutive windows
    do_load(2, 7);
    wait_busy(bc);
    check("busy_len_27", bc, 3);
    observe(P, r, tg, mn, mx);
    check("rises_27_w1", r, 27);
    observe(P, r, tg, mn, mx);
    check("rises_27_w2", r, 27);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
- Programmable square-wave source: the transmit-side counterpart of the frequency counter.
- Takes a two-digit BCD rate (tens, units) and drives `signal` with exactly N = 10*tens + units rising edges per UPDATE_PERIOD clocks.
- Used as an on-chip stimulus and loopback source for the counter.
- Generates edges with a phase accumulator, so the rate is exact and free of rounding error.

Parameters:
- UPDATE_PERIOD, 1200: measurement window length in clocks; the output has N rising edges per window.
- BITS, 12: accumulator width. Requires UPDATE_PERIOD + 198 < 2^BITS.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load  input  1  single-cycle strobe; latches ten_count and unit_count when not busy
- ten_count  input  4  BCD tens digit of N
- unit_count  input  4  BCD units digit of N
- busy  output  1  high while a loaded value is being converted; loads are ignored while high
- running  output  1  high in RUN with N != 0
- signal  output  1  generated square wave, registered

Behaviour:
- Reset, sampled on clk:
  - state = IDLE; busy = 0; running = 0; signal = 0.
  - acc = 0; step = 0; tens_left = 0; units = 0.
  - Reset overrides load and applies mid-CONVERT or mid-RUN; signal is 0 the cycle after reset is sampled.
- Digit clamp: at load, any digit > 9 is latched as 9.
- States:
  - IDLE: signal held 0. Exit to CONVERT on load.
  - CONVERT: building step = 2N.
  - RUN: generating.
  - Illegal state encodings go to IDLE.
- Load acceptance, when load=1 in IDLE or RUN:
  - tens_left = clamp(ten_count); units = clamp(unit_count).
  - step = 0; acc = 0; busy = 1; running = 0.
  - state goes to CONVERT.
  - signal keeps its current level.
- Load while busy (CONVERT) is ignored entirely.
- CONVERT, one cycle per step:
  - If tens_left != 0: step += 20; tens_left -= 1.
  - Otherwise: step += 2*units; busy = 0; state goes to RUN; running = (final step != 0).
  - CONVERT therefore lasts T+1 cycles for tens digit T.
  - busy is high exactly T+1 cycles, starting the cycle after load.
  - Max busy duration is 10 cycles (T=9).
- RUN, every cycle:
  - If step == 0: signal forced to 0 and acc unchanged.
  - Else, sum = acc + step computed in BITS+1 bits:
    - if sum >= UPDATE_PERIOD: acc = sum - UPDATE_PERIOD and signal toggles;
    - else acc = sum.
- Output rate:
  - step <= 198 < UPDATE_PERIOD, so at most one toggle per cycle.
  - Any UPDATE_PERIOD consecutive RUN cycles contain exactly 2N toggles, i.e. exactly N rising edges.
  - Toggle spacing is floor or ceil of UPDATE_PERIOD/(2N); high/low phases differ by at most 1 clock.
- First toggle after RUN entry occurs on cycle ceil(UPDATE_PERIOD/step) of RUN (1-based).
- Reload in RUN with the same value restarts the phase: acc = 0, and signal keeps its level.
- No combinational path from any input to any output.

Test Plan:
- Reset, then load 0/5 -> busy=1 for exactly 1 cycle; running=1; step=10; first toggle on RUN cycle 120; exactly 5 rising edges in any 1200-cycle RUN window; toggle spacing exactly 120.
- Load 9/9 -> busy=1 for exactly 10 cycles; step=198; exactly 99 rising edges per 1200-cycle window; every high and low phase lasts 6 or 7 cycles.
- Load 0/0 from RUN (signal high) -> after 1 busy cycle, running=0 and signal=0, held for 2000 cycles.
- Load 4/2, then pulse load 0/1 during busy cycle 2 -> second load ignored; 42 rising edges per window. Load 15/12 -> clamped to 9/9, 99 edges per window.
- Reset asserted mid-RUN and mid-CONVERT -> next cycle: signal=0, busy=0, running=0, state IDLE; no toggles until a new load.
- Loopback of signal into the frequency counter after load 2/7 -> counter's ten_count/unit_count equal 2/7 (±1 unit for window alignment) on every update.
